// File: rtl/cfg_lut_pkg.sv
// rtl/cfg_lut_pkg.sv - shared state type and shift helpers for the reconfigurable LUT6_2
package cfg_lut_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} lut_state_e;

  localparam int TABLE_W = 64;

  function automatic int shift_count(input int shift_w);
    return TABLE_W / shift_w;
  endfunction

  function automatic bit shift_w_legal(input int shift_w);
    return (shift_w > 0) && (shift_w <= TABLE_W) &&
           ((shift_w & (shift_w - 1)) == 0) && ((TABLE_W % shift_w) == 0);
  endfunction

  // Pushes a zero-extended slice in at the LSB end; written as shift/or so SHIFT_W=64 needs no special case.
  function automatic logic [63:0] push_slice(input logic [63:0] cur, input logic [63:0] slice,
                                             input int shift_w);
    return (cur << shift_w) | slice;
  endfunction

endpackage

// File: rtl/cfg_lut_shifter.sv
// rtl/cfg_lut_shifter.sv - load handshake, staging register and serial shift sequencing
module cfg_lut_shifter
  import cfg_lut_pkg::*;
#(
  parameter int SHIFT_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  input  logic [63:0]        ld_data,
  output logic               ld_ready,
  input  logic               ce,
  output logic               busy,
  output logic               done,
  output logic [SHIFT_W-1:0] shift_slice,
  output logic               shift_en,
  output logic               last_shift
);

  localparam int N  = shift_count(SHIFT_W);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!shift_w_legal(SHIFT_W)) begin : g_bad_shift_w
    $error("cfg_lut_shifter: SHIFT_W must be a power of two dividing 64");
  end

  lut_state_e    state, state_next;
  logic [63:0]   stage;
  logic [CW-1:0] cnt;
  logic          done_q;

  always_comb begin
    state_next = state;
    ld_ready   = (state == IDLE) & ~rst;
    shift_en   = (state == SHIFT) & ce;
    last_shift = shift_en & (cnt == LAST);
    case (state)
      IDLE:    if (ld_valid && ld_ready) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      stage  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= last_shift;
      if (state == IDLE && ld_valid) begin
        stage <= ld_data;
        cnt   <= '0;
      end else if (shift_en) begin
        stage <= stage << SHIFT_W;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  assign shift_slice = stage[63 -: SHIFT_W];
  assign busy        = (state == SHIFT);
  assign done        = done_q;

endmodule

// File: rtl/cfg_lut6_2.sv
// rtl/cfg_lut6_2.sv - run-time reconfigurable LUT6_2 with serial table load
module cfg_lut6_2
  import cfg_lut_pkg::*;
#(
  parameter logic [63:0] INIT    = 64'h0000000000000000,
  parameter int          SHIFT_W = 1,
  parameter bit          SHADOW  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I0,
  input  logic        I1,
  input  logic        I2,
  input  logic        I3,
  input  logic        I4,
  input  logic        I5,
  output logic        O5,
  output logic        O6,
  input  logic        LD_VALID,
  input  logic [63:0] LD_DATA,
  output logic        LD_READY,
  input  logic        CE,
  output logic        BUSY,
  output logic        DONE
);

  logic [63:0]        active, shadow;
  logic [63:0]        active_next, shadow_next, slice_ext;
  logic [SHIFT_W-1:0] slice;
  logic               shift_en, last_shift;
  logic [5:0]         addr;

  cfg_lut_shifter #(.SHIFT_W(SHIFT_W)) u_shifter (
    .clk        (CLK),
    .rst        (RST),
    .ld_valid   (LD_VALID),
    .ld_data    (LD_DATA),
    .ld_ready   (LD_READY),
    .ce         (CE),
    .busy       (BUSY),
    .done       (DONE),
    .shift_slice(slice),
    .shift_en   (shift_en),
    .last_shift (last_shift)
  );

  assign slice_ext   = 64'(slice);
  assign shadow_next = push_slice(shadow, slice_ext, SHIFT_W);
  assign active_next = push_slice(active, slice_ext, SHIFT_W);

  // Shadow mode swaps the completed table in on the final shift edge; otherwise the live table shifts in place.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active <= INIT;
      shadow <= '0;
    end else if (shift_en) begin
      if (SHADOW) begin
        shadow <= shadow_next;
        if (last_shift) active <= shadow_next;
      end else begin
        active <= active_next;
      end
    end
  end

  assign addr = {I5, I4, I3, I2, I1, I0};
  assign O6   = active[addr];
  assign O5   = active[{1'b0, addr[4:0]}];

endmodule

// File: tb/tb_cfg_lut6_2.sv
// tb/tb_cfg_lut6_2.sv - randomized and directed checks of cfg_lut6_2 against a table-level model
`timescale 1ns/1ps
module tb_cfg_lut6_2;

  localparam logic [63:0] INIT_A = 64'h8000_0000_0000_0001;
  localparam logic [63:0] INIT_B = 64'h0000_0000_0000_0000;
  localparam logic [63:0] INIT_C = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] INIT_D = 64'hDEAD_BEEF_0BAD_F00D;

  logic        CLK;
  logic        rst, ld_valid, ce;
  logic [63:0] ld_data;
  logic [5:0]  addr;
  wire  [3:0]  o5_w, o6_w, rdy_w, bsy_w, dn_w;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_act[4], m_tgt[4], m_base[4];
  int          m_k[4];
  bit          m_busy[4], m_done[4];
  logic [63:0] t6[4], t5[4];
  int          cyc = 0;

  cfg_lut6_2 #(.INIT(INIT_A), .SHIFT_W(1), .SHADOW(1'b1)) u_a (
    .CLK(CLK), .RST(rst), .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]),
    .I4(addr[4]), .I5(addr[5]), .O5(o5_w[0]), .O6(o6_w[0]), .LD_VALID(ld_valid),
    .LD_DATA(ld_data), .LD_READY(rdy_w[0]), .CE(ce), .BUSY(bsy_w[0]), .DONE(dn_w[0]));
  cfg_lut6_2 #(.INIT(INIT_B), .SHIFT_W(4), .SHADOW(1'b1)) u_b (
    .CLK(CLK), .RST(rst), .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]),
    .I4(addr[4]), .I5(addr[5]), .O5(o5_w[1]), .O6(o6_w[1]), .LD_VALID(ld_valid),
    .LD_DATA(ld_data), .LD_READY(rdy_w[1]), .CE(ce), .BUSY(bsy_w[1]), .DONE(dn_w[1]));
  cfg_lut6_2 #(.INIT(INIT_C), .SHIFT_W(8), .SHADOW(1'b0)) u_c (
    .CLK(CLK), .RST(rst), .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]),
    .I4(addr[4]), .I5(addr[5]), .O5(o5_w[2]), .O6(o6_w[2]), .LD_VALID(ld_valid),
    .LD_DATA(ld_data), .LD_READY(rdy_w[2]), .CE(ce), .BUSY(bsy_w[2]), .DONE(dn_w[2]));
  cfg_lut6_2 #(.INIT(INIT_D), .SHIFT_W(64), .SHADOW(1'b0)) u_d (
    .CLK(CLK), .RST(rst), .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]),
    .I4(addr[4]), .I5(addr[5]), .O5(o5_w[3]), .O6(o6_w[3]), .LD_VALID(ld_valid),
    .LD_DATA(ld_data), .LD_READY(rdy_w[3]), .CE(ce), .BUSY(bsy_w[3]), .DONE(dn_w[3]));

  initial CLK = 1'b0;
  always #500 CLK = ~CLK;

  function automatic int w_of(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic bit sh_of(input int i);
    return (i < 2);
  endfunction

  function automatic logic [63:0] init_of(input int i);
    case (i)
      0: return INIT_A;
      1: return INIT_B;
      2: return INIT_C;
      default: return INIT_D;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Table-level model: a load is a target word plus a count of shifts completed.
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      logic [127:0] cat;
      int n;
      n = 64 / w_of(i);
      m_done[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
        m_act[i]  = init_of(i);
      end else if (!m_busy[i]) begin
        if (ld_valid) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
          m_tgt[i]  = ld_data;
          m_base[i] = m_act[i];
        end
      end else if (ce) begin
        m_k[i]++;
        if (m_k[i] == n) begin
          m_busy[i] = 1'b0;
          m_act[i]  = m_tgt[i];
          m_done[i] = 1'b1;
        end else if (!sh_of(i)) begin
          cat      = {m_base[i], m_tgt[i]} << (m_k[i] * w_of(i));
          m_act[i] = cat[127:64];
        end
      end
    end
  endtask

  task automatic check_all();
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      for (int i = 0; i < 4; i++) begin
        t6[i][a] = o6_w[i];
        t5[i][a] = o5_w[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("u%0d.o6_table c%0d", i, cyc), t6[i], m_act[i]);
      check_val($sformatf("u%0d.o5_table c%0d", i, cyc), t5[i], {m_act[i][31:0], m_act[i][31:0]});
      check_val($sformatf("u%0d.ld_ready c%0d", i, cyc), 64'(rdy_w[i]), 64'(!m_busy[i] && !rst));
      check_val($sformatf("u%0d.busy c%0d", i, cyc), 64'(bsy_w[i]), 64'(m_busy[i]));
      check_val($sformatf("u%0d.done c%0d", i, cyc), 64'(dn_w[i]), 64'(m_done[i]));
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, step model, then check at the next falling edge.
  task automatic cycle(input bit r, input bit v, input logic [63:0] d, input bit c);
    rst      = r;
    ld_valid = v;
    ld_data  = d;
    ce       = c;
    addr     = 6'($urandom_range(0, 63));
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    cyc++;
    check_all();
  endtask

  initial begin
    int rl, dc, j_done, d1, d2;
    logic [63:0] d;
    rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ce = 1'b0; addr = '0;
    @(negedge CLK);

    cycle(1, 0, 64'h0, 0);
    cycle(1, 0, 64'h0, 0);
    check_val("a_reset_o6", t6[0], 64'h8000_0000_0000_0001);
    check_val("a_reset_o5", t5[0], 64'h0000_0001_0000_0001);
    check_val("a_reset_flags", {61'b0, rdy_w[0], bsy_w[0], dn_w[0]}, 64'h0);
    cycle(0, 0, 64'h0, 0);
    check_val("a_ready_idle", 64'(rdy_w[0]), 64'h1);

    cycle(0, 1, 64'hA5C3_0F96_1234_5678, 1);
    cycle(0, 0, 64'h0, 1);
    check_val("c_first_shift", t6[2], 64'h2345_6789_ABCD_EFA5);
    check_val("d_single_shift", t6[3], 64'hA5C3_0F96_1234_5678);
    repeat (70) cycle(0, 0, 64'h0, 1);

    rl = 0; dc = 0;
    cycle(0, 1, 64'hFFFF_FFFF_0000_0000, 1);
    rl += !rdy_w[0];
    for (int j = 0; j < 70; j++) begin
      cycle(0, 0, 64'h0, 1);
      rl += !rdy_w[0];
      dc += dn_w[0];
    end
    check_val("a_ready_low_cycles", 64'(rl), 64'd64);
    check_val("a_done_pulses", 64'(dc), 64'd1);
    check_val("a_loaded", t6[0], 64'hFFFF_FFFF_0000_0000);

    d = {$urandom, $urandom};
    j_done = -1;
    cycle(0, 1, d, 1);
    for (int j = 1; j <= 80; j++) begin
      cycle(0, 0, 64'h0, (j % 2) == 1);
      if (dn_w[1] && j_done < 0) j_done = j;
    end
    check_val("b_done_cycle", 64'(j_done), 64'd31);
    check_val("b_table", t6[1], d);

    d1 = -1; d2 = -1;
    cycle(0, 1, 64'h1, 1);
    for (int j = 1; j <= 140; j++) begin
      cycle(0, 1, 64'h2, 1);
      if (dn_w[0]) begin
        if (d1 < 0) d1 = j;
        else if (d2 < 0) d2 = j;
      end
    end
    check_val("a_b2b_gap", 64'(d2 - d1), 64'd65);
    check_val("a_b2b_table", t6[0], 64'h2);
    repeat (70) cycle(0, 0, 64'h0, 1);

    cycle(0, 1, {$urandom, $urandom}, 1);
    repeat (9) cycle(0, 0, 64'h0, 1);
    cycle(1, 0, 64'h0, 1);
    check_val("a_rst_midload_o6", t6[0], INIT_A);
    check_val("a_rst_midload_done", 64'(dn_w[0]), 64'h0);
    cycle(0, 0, 64'h0, 1);
    check_val("a_ready_after_rst", 64'(rdy_w[0]), 64'h1);

    for (int j = 0; j < 1200; j++)
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
            {$urandom, $urandom}, ($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_lut6_2.md
# cfg_lut6_2

Run-time reconfigurable 6-input, dual-output LUT for Verilator models of Xilinx designs. Lookup is identical to LUT6_2: O6 is indexed by {I5..I0} and O5 by {0,I4..I0}, so O5 always reads table bits [31:0]. A new 64-bit table is accepted over a valid/ready handshake and shifted into the LUT serially, SHIFT_W bits per enabled cycle, which reproduces the cycle cost of in-fabric LUT reconfiguration. The block sits directly upstream of the LUT evaluation and supplies its table contents.

## Interface
- INIT, 64'h0000000000000000, table value after reset
- SHIFT_W, 1, bits shifted per enabled cycle; legal values 1, 2, 4, 8, 16, 32, 64
- SHADOW, 1, 1 = new table applied atomically at completion; 0 = active table shifted in place

- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-high
- I0..I5  in  1 each  lookup address
- O5  out  1  combinational, active[{1'b0,I4,I3,I2,I1,I0}]
- O6  out  1  combinational, active[{I5,I4,I3,I2,I1,I0}]
- LD_VALID  in  1  load request
- LD_DATA  in  64  new table, bit n = entry n
- LD_READY  out  1  block can accept a load
- CE  in  1  shift enable
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle pulse: new table is visible

## Operation
- N = 64/SHIFT_W shifts per load. The shift counter is ceil(log2(N+1)) bits wide.
- States:
  - IDLE: LD_READY=1, BUSY=0.
  - SHIFT: LD_READY=0, BUSY=1.
- Accept: LD_VALID & LD_READY at an edge. At that edge, stage <= LD_DATA, cnt <= 0, state -> SHIFT.
- SHIFT, at an edge with CE=1:
  - SHADOW=1: shadow <= {shadow[63-SHIFT_W:0], stage[63 -: SHIFT_W]}.
  - SHADOW=0: the same shift is applied to active.
  - stage <<= SHIFT_W; cnt++.
  - Data is loaded MSB first. After N shifts the target register equals LD_DATA.
- Final shift (cnt == N-1 with CE=1):
  - SHADOW=1: active <= the completed shadow value, on the same edge.
  - state -> IDLE; DONE=1 for the following cycle.
- SHIFT with CE=0: all state held, no progress.
- SHADOW=0: O5/O6 reflect partially shifted contents during a load. This is intended.
- LD_DATA is ignored except at the accept edge. LD_VALID while busy is held off by LD_READY=0 and is not dropped.
- SHIFT_W=64: N=1, and the load completes at the first CE edge after accept.

## Timing
- Reset values:
  - active = INIT; shadow = 0; stage = 0; cnt = 0; state = IDLE.
  - BUSY=0, DONE=0.
  - O5/O6 follow the INIT lookup combinationally.
- LD_READY = (state == IDLE) & ~RST. It is low during any cycle with RST high.
- Latency with CE held high: accept at edge k, shifts at edges k+1..k+N. The new table is visible after edge k+N, with DONE high in the cycle that follows.
- Back-to-back loads: LD_READY=1 in the DONE cycle, so a second accept is allowed there. No bubble is required beyond the accept edge.
- Reset mid-load: abort at the next edge. active returns to INIT in both SHADOW modes, partial data is discarded, and DONE is not asserted.
- RST with LD_VALID: the reset wins and nothing is accepted.
- O5/O6 have zero latency from I0..I5; there is no register on the read path.

## Structure
- Package cfg_lut_pkg:
  - state enum {IDLE, SHIFT}.
  - function shift_count(SHIFT_W) returning N.
  - elaboration check that SHIFT_W divides 64 and is a power of two.
- Sub-module cfg_lut_shifter: holds stage, cnt and the FSM; emits the shift-in slice, shift strobe, last-shift flag and DONE.
- Top level: holds the active and shadow registers and the O5/O6 read mux.

## Test plan
- Reset, INIT=64'h8000_0000_0000_0001: I=6'h00 -> O5=O6=1. I=6'h3F -> O6=1, O5=0. BUSY=DONE=0, LD_READY=1.
- SHIFT_W=1, SHADOW=1, CE=1, load 64'hFFFF_FFFF_0000_0000 from INIT=0:
  - LD_READY=0 for 64 cycles.
  - O6 at I=6'h20 stays 0 through edge 63 and reads 1 after edge 64; DONE is a single pulse.
  - O5 stays 0 throughout.
- SHIFT_W=4, CE alternating 1/0: completion after exactly 16 CE-high edges (31 cycles). Table equals LD_DATA.
- SHADOW=0, SHIFT_W=8, INIT=64'h0123_4567_89AB_CDEF, load 64'hA5xx...: after the first shift, active = 64'h2345_6789_ABCD_EFA5.
- Back-to-back: LD_VALID held with 64'h1 then 64'h2. The second word is accepted in the DONE cycle and its DONE comes N+1 cycles after the first DONE.
- RST asserted at the 10th shift, SHADOW=1: O6 lookup equals INIT next cycle, no DONE, LD_READY=1 the cycle after RST drops.
